// File: rtl/ex_mem_reg_pkg.sv
// ex_mem_reg_pkg: shared defines for the EX/MEM pipeline register
//   RstEnable      - level of rst that asserts reset (active low)
//   ZeroWord       - all-zero datapath word
//   NOPRegAddr     - destination address used by a bubble
//   WriteDisable   - write-enable level used by a bubble
//   RegBus/RegAddrBus/AluOpBus/DoubleRegBus - default bus types
//   StallEx/StallMem - stall vector bit owned by ex_mem / mem_wb
//   ex_mem_act_e/ex_mem_action - per-edge action decoded from flush and stall
package ex_mem_reg_pkg;

   localparam int DataW    = 32;
   localparam int RegAddrW = 5;
   localparam int AluOpW   = 8;
   localparam int CntW     = 2;
   localparam int StallW   = 6;

   localparam int StallEx  = 3;
   localparam int StallMem = 4;

   localparam logic                RstEnable    = 1'b0;
   localparam logic                WriteEnable  = 1'b1;
   localparam logic                WriteDisable = 1'b0;
   localparam logic [DataW-1:0]    ZeroWord     = '0;
   localparam logic [RegAddrW-1:0] NOPRegAddr   = '0;
   localparam logic [AluOpW-1:0]   NOPAluOp     = '0;

   typedef logic [DataW-1:0]    RegBus;
   typedef logic [RegAddrW-1:0] RegAddrBus;
   typedef logic [AluOpW-1:0]   AluOpBus;
   typedef logic [2*DataW-1:0]  DoubleRegBus;

   // ACT_FLUSH and ACT_BUBBLE both clear the memory-stage outputs; they
   // differ only in whether the madd/msub accumulator is captured.
   typedef enum logic [1:0] {
      ACT_ADVANCE,
      ACT_BUBBLE,
      ACT_HOLD,
      ACT_FLUSH
   } ex_mem_act_e;

   // Flush beats any stall. A stalled EX with a running MEM becomes a bubble;
   // a stalled MEM freezes everything. The stall vector is monotonic, so
   // stall[StallMem] without stall[StallEx] is treated as a normal advance.
   function automatic ex_mem_act_e ex_mem_action(input logic flush, input logic [StallW-1:0] stall);
      return flush ? ACT_FLUSH :
             !stall[StallEx] ? ACT_ADVANCE :
             stall[StallMem] ? ACT_HOLD : ACT_BUBBLE;
   endfunction

endpackage

// File: rtl/ex_mem_reg.sv
// ex_mem_reg: EX/MEM pipeline register with stall, flush and madd/msub accumulator loop-back
//   clk          core clock
//   rst          asynchronous active-low reset
//   stall        stall vector from ctrl (bit3 ex_mem, bit4 mem_wb)
//   flush        exception flush from ctrl
//   ex_*         execute-stage results to be latched
//   hilo_i/cnt_i madd/msub partial result and cycle index from execute
//   mem_*        registered copies presented to the memory stage
//   hilo_o/cnt_o accumulator state returned to execute across a stall
module ex_mem_reg
   import ex_mem_reg_pkg::*;
#(
   parameter int DATA_W     = DataW,
   parameter int REG_ADDR_W = RegAddrW,
   parameter int ALUOP_W    = AluOpW,
   parameter int CNT_W      = CntW
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [StallW-1:0]     stall,
   input  logic                  flush,
   input  logic [REG_ADDR_W-1:0] ex_wd,
   input  logic                  ex_wreg,
   input  logic [DATA_W-1:0]     ex_wdata,
   input  logic                  ex_whilo,
   input  logic [DATA_W-1:0]     ex_hi,
   input  logic [DATA_W-1:0]     ex_lo,
   input  logic [ALUOP_W-1:0]    ex_aluop,
   input  logic [DATA_W-1:0]     ex_mem_addr,
   input  logic [DATA_W-1:0]     ex_reg2,
   input  logic [2*DATA_W-1:0]   hilo_i,
   input  logic [CNT_W-1:0]      cnt_i,
   output logic [REG_ADDR_W-1:0] mem_wd,
   output logic                  mem_wreg,
   output logic [DATA_W-1:0]     mem_wdata,
   output logic                  mem_whilo,
   output logic [DATA_W-1:0]     mem_hi,
   output logic [DATA_W-1:0]     mem_lo,
   output logic [ALUOP_W-1:0]    mem_aluop,
   output logic [DATA_W-1:0]     mem_mem_addr,
   output logic [DATA_W-1:0]     mem_reg2,
   output logic [2*DATA_W-1:0]   hilo_o,
   output logic [CNT_W-1:0]      cnt_o
);

   ex_mem_act_e act;
   logic        pass;
   logic        keep_acc;

   assign act      = ex_mem_action(flush, stall);
   assign pass     = act == ACT_ADVANCE;
   // Only a bubble carries the accumulator; advance and flush restart it.
   assign keep_acc = act == ACT_BUBBLE;

   always_ff @(posedge clk or negedge rst) begin
      if (rst == RstEnable) begin
         mem_wd       <= '0;
         mem_wreg     <= WriteDisable;
         mem_wdata    <= '0;
         mem_whilo    <= WriteDisable;
         mem_hi       <= '0;
         mem_lo       <= '0;
         mem_aluop    <= '0;
         mem_mem_addr <= '0;
         mem_reg2     <= '0;
         hilo_o       <= '0;
         cnt_o        <= '0;
      end else if (act != ACT_HOLD) begin
         mem_wd       <= pass ? ex_wd       : REG_ADDR_W'(NOPRegAddr);
         mem_wreg     <= pass ? ex_wreg     : WriteDisable;
         mem_wdata    <= pass ? ex_wdata    : DATA_W'(ZeroWord);
         mem_whilo    <= pass ? ex_whilo    : WriteDisable;
         mem_hi       <= pass ? ex_hi       : DATA_W'(ZeroWord);
         mem_lo       <= pass ? ex_lo       : DATA_W'(ZeroWord);
         mem_aluop    <= pass ? ex_aluop    : ALUOP_W'(NOPAluOp);
         mem_mem_addr <= pass ? ex_mem_addr : DATA_W'(ZeroWord);
         mem_reg2     <= pass ? ex_reg2     : DATA_W'(ZeroWord);
         hilo_o       <= keep_acc ? hilo_i : '0;
         cnt_o        <= keep_acc ? cnt_i  : '0;
      end
   end

endmodule

// File: tb/tb_ex_mem_reg.sv
// tb_ex_mem_reg: randomized self-checking bench for ex_mem_reg against a behavioural model
module tb_ex_mem_reg;

   typedef struct packed {
      logic [4:0]  wd;
      logic        wreg;
      logic [31:0] wdata;
      logic        whilo;
      logic [31:0] hi;
      logic [31:0] lo;
      logic [7:0]  aluop;
      logic [31:0] addr;
      logic [31:0] reg2;
      logic [63:0] hilo;
      logic [1:0]  cnt;
   } st_t;

   logic        clk = 0;
   logic        rst = 1;
   logic [5:0]  stall = '0;
   logic        flush = 0;
   logic [4:0]  ex_wd = '0;
   logic        ex_wreg = 0;
   logic [31:0] ex_wdata = '0;
   logic        ex_whilo = 0;
   logic [31:0] ex_hi = '0;
   logic [31:0] ex_lo = '0;
   logic [7:0]  ex_aluop = '0;
   logic [31:0] ex_mem_addr = '0;
   logic [31:0] ex_reg2 = '0;
   logic [63:0] hilo_i = '0;
   logic [1:0]  cnt_i = '0;
   logic [4:0]  mem_wd;
   logic        mem_wreg;
   logic [31:0] mem_wdata;
   logic        mem_whilo;
   logic [31:0] mem_hi;
   logic [31:0] mem_lo;
   logic [7:0]  mem_aluop;
   logic [31:0] mem_mem_addr;
   logic [31:0] mem_reg2;
   logic [63:0] hilo_o;
   logic [1:0]  cnt_o;

   st_t act_s;
   st_t exp_s = '0;
   int  total = 0;
   int  bad = 0;

   ex_mem_reg dut (
      .clk(clk), .rst(rst), .stall(stall), .flush(flush),
      .ex_wd(ex_wd), .ex_wreg(ex_wreg), .ex_wdata(ex_wdata), .ex_whilo(ex_whilo),
      .ex_hi(ex_hi), .ex_lo(ex_lo), .ex_aluop(ex_aluop), .ex_mem_addr(ex_mem_addr),
      .ex_reg2(ex_reg2), .hilo_i(hilo_i), .cnt_i(cnt_i),
      .mem_wd(mem_wd), .mem_wreg(mem_wreg), .mem_wdata(mem_wdata), .mem_whilo(mem_whilo),
      .mem_hi(mem_hi), .mem_lo(mem_lo), .mem_aluop(mem_aluop), .mem_mem_addr(mem_mem_addr),
      .mem_reg2(mem_reg2), .hilo_o(hilo_o), .cnt_o(cnt_o)
   );

   assign act_s = {mem_wd, mem_wreg, mem_wdata, mem_whilo, mem_hi, mem_lo, mem_aluop,
                   mem_mem_addr, mem_reg2, hilo_o, cnt_o};

   always #5 clk = ~clk;

   // Reference behaviour: what the register should hold after the coming edge.
   task automatic model_edge();
      if (!rst || flush) exp_s = '0;
      else if (!stall[3]) exp_s = {ex_wd, ex_wreg, ex_wdata, ex_whilo, ex_hi, ex_lo, ex_aluop,
                                   ex_mem_addr, ex_reg2, 64'h0, 2'h0};
      else if (!stall[4]) begin
         exp_s = '0;
         exp_s.hilo = hilo_i;
         exp_s.cnt = cnt_i;
      end
   endtask

   task automatic tick();
      model_edge();
      @(posedge clk);
      #1;
   endtask

   task automatic rand_ex();
      ex_wd = 5'($urandom);
      ex_wreg = 1'($urandom);
      ex_wdata = $urandom;
      ex_whilo = 1'($urandom);
      ex_hi = $urandom;
      ex_lo = $urandom;
      ex_aluop = 8'($urandom);
      ex_mem_addr = $urandom;
      ex_reg2 = $urandom;
      hilo_i = {$urandom, $urandom};
      cnt_i = 2'($urandom);
   endtask

   task automatic test_reset();
      rand_ex();
      stall = 6'($urandom);
      #2 rst = 0;
      #1;
      exp_s = '0;
      total++;
      if (act_s !== exp_s) begin bad++; $display("FAIL reset_async act=%h exp=%h", act_s, exp_s); end
      tick();
      total++;
      if (act_s !== exp_s) begin bad++; $display("FAIL reset_held act=%h exp=%h", act_s, exp_s); end
      rand_ex();
      rst = 1;
      flush = 0;
      stall = '0;
      ex_wd = 5'd3;
      ex_wreg = 1;
      ex_wdata = 32'hDEADBEEF;
      tick();
      total++;
      if ({mem_wd, mem_wreg, mem_wdata} !== {5'd3, 1'b1, 32'hDEADBEEF}) begin
         bad++;
         $display("FAIL reset_release act=%h/%b/%h exp=3/1/deadbeef", mem_wd, mem_wreg, mem_wdata);
      end
      total++;
      if (act_s !== exp_s) begin bad++; $display("FAIL reset_release_all act=%h exp=%h", act_s, exp_s); end
   endtask

   task automatic test_bubble();
      rand_ex();
      tick();
      stall = 6'b001111;
      ex_wreg = 1;
      ex_whilo = 1;
      hilo_i = 64'h1_0000_0002;
      cnt_i = 2'd1;
      tick();
      total++;
      if ({mem_wreg, mem_whilo, mem_wd} !== 7'b0) begin
         bad++;
         $display("FAIL bubble_nowrite act=%b/%b/%h exp=0/0/0", mem_wreg, mem_whilo, mem_wd);
      end
      total++;
      if ({hilo_o, cnt_o} !== {64'h1_0000_0002, 2'd1}) begin
         bad++;
         $display("FAIL bubble_acc act=%h/%h exp=100000002/1", hilo_o, cnt_o);
      end
      total++;
      if (act_s !== exp_s) begin bad++; $display("FAIL bubble_all act=%h exp=%h", act_s, exp_s); end
   endtask

   task automatic test_hold();
      rand_ex();
      stall = 6'b001111;
      tick();
      rand_ex();
      stall = '0;
      ex_wdata = 32'h12345678;
      tick();
      for (int i = 0; i < 3; i++) begin
         rand_ex();
         stall = 6'b011111;
         tick();
         total++;
         if (mem_wdata !== 32'h12345678 || {hilo_o, cnt_o} !== 66'h0) begin
            bad++;
            $display("FAIL hold_%0d act=%h/%h/%h exp=12345678/0/0", i, mem_wdata, hilo_o, cnt_o);
         end
      end
      rand_ex();
      stall = 6'b001111;
      tick();
      for (int i = 0; i < 2; i++) begin
         rand_ex();
         stall = 6'b011111;
         tick();
         total++;
         if (act_s !== exp_s) begin bad++; $display("FAIL hold_acc_%0d act=%h exp=%h", i, act_s, exp_s); end
      end
   endtask

   task automatic test_flush();
      rand_ex();
      stall = '0;
      tick();
      rand_ex();
      flush = 1;
      stall = 6'b011111;
      tick();
      total++;
      if (act_s !== 241'h0) begin bad++; $display("FAIL flush_over_hold act=%h exp=0", act_s); end
      flush = 0;
      stall = 6'b001111;
      rand_ex();
      cnt_i = 2'd1;
      tick();
      rand_ex();
      flush = 1;
      stall = 6'b001111;
      tick();
      total++;
      if (act_s !== 241'h0) begin bad++; $display("FAIL flush_over_bubble act=%h exp=0", act_s); end
      flush = 0;
   endtask

   task automatic test_async_reset();
      rand_ex();
      stall = 6'b001111;
      cnt_i = 2'd1;
      tick();
      total++;
      if (cnt_o !== 2'd1) begin bad++; $display("FAIL async_pre act=%h exp=1", cnt_o); end
      #2 rst = 0;
      #1;
      exp_s = '0;
      total++;
      if (act_s !== exp_s) begin bad++; $display("FAIL async_mid act=%h exp=0", act_s); end
      #1 rst = 1;
      rand_ex();
      stall = '0;
      tick();
      total++;
      if (act_s !== exp_s) begin bad++; $display("FAIL async_release act=%h exp=%h", act_s, exp_s); end
   endtask

   task automatic test_store();
      rand_ex();
      stall = '0;
      ex_wreg = 0;
      ex_aluop = 8'b11101011;
      ex_mem_addr = 32'h0000_0040;
      ex_reg2 = 32'hCAFEF00D;
      tick();
      total++;
      if ({mem_aluop, mem_mem_addr, mem_reg2, mem_wreg} !== {8'b11101011, 32'h40, 32'hCAFEF00D, 1'b0}) begin
         bad++;
         $display("FAIL store act=%h/%h/%h/%b exp=eb/40/cafef00d/0", mem_aluop, mem_mem_addr, mem_reg2, mem_wreg);
      end
   endtask

   task automatic test_madd();
      logic [63:0] part;
      rand_ex();
      part = {$urandom, $urandom};
      stall = 6'b001111;
      hilo_i = part;
      cnt_i = 2'd1;
      tick();
      total++;
      if ({hilo_o, cnt_o} !== {part, 2'd1}) begin
         bad++;
         $display("FAIL madd_return act=%h/%h exp=%h/1", hilo_o, cnt_o, part);
      end
      rand_ex();
      stall = '0;
      tick();
      total++;
      if ({hilo_o, cnt_o} !== 66'h0) begin bad++; $display("FAIL madd_done act=%h/%h exp=0/0", hilo_o, cnt_o); end
      total++;
      if (act_s !== exp_s) begin bad++; $display("FAIL madd_done_all act=%h exp=%h", act_s, exp_s); end
   endtask

   task automatic test_random();
      int k;
      for (int i = 0; i < 400; i++) begin
         rand_ex();
         k = $urandom_range(0, 6);
         stall = 6'((1 << k) - 1);
         flush = $urandom_range(0, 15) == 0;
         tick();
         total++;
         if (act_s !== exp_s) begin bad++; $display("FAIL random_%0d act=%h exp=%h", i, act_s, exp_s); end
      end
      flush = 0;
   endtask

   initial begin
      test_reset();
      test_bubble();
      test_hold();
      test_flush();
      test_async_reset();
      test_store();
      test_madd();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
